// File: rtl/mdu_if.sv
// Multiply/divide unit bus: operation request from the E stage and HI/LO/busy back.
interface mdu_if;
  logic        req;      // flush this cycle: drop any new MDU action
  logic [3:0]  mdu_op;
  logic [31:0] a;        // rs operand
  logic [31:0] b;        // rt operand
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (output req, mdu_op, a, b, input busy, hi, lo, rd_data);
  modport slave  (input req, mdu_op, a, b, output busy, hi, lo, rd_data);
endinterface

// File: rtl/mdu.sv
// MIPS multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU, owns HI/LO,
// serves MTHI/MTLO/MFHI/MFLO. The result is computed at start and held in a
// pending register until the busy window expires, so latency is a pure counter.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk_i,
  input  logic  reset_i,
  mdu_if.slave  bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic { S_IDLE, S_BUSY } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic          pwr_q, pwr_d;    // pending result is to be committed (cleared on divide by zero)

  logic          accept;
  logic          is_signed;
  logic [63:0]   xa, xb, prod;
  logic [31:0]   ua, ub, qmag, rmag, quo, rem;

  assign accept    = (state_q == S_IDLE) & ~bus.req;
  assign is_signed = (bus.mdu_op == OP_MULT) | (bus.mdu_op == OP_DIV);

  // Datapath: sign/zero-extended 64-bit product, sign-magnitude divide.
  // Dividing magnitudes makes 0x80000000 / -1 fall out naturally as 0x80000000 r 0.
  always_comb begin
    xa   = is_signed ? {{32{bus.a[31]}}, bus.a} : {32'b0, bus.a};
    xb   = is_signed ? {{32{bus.b[31]}}, bus.b} : {32'b0, bus.b};
    prod = xa * xb;
    ua   = (is_signed & bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    ub   = (is_signed & bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    if (ub == 32'd0) ub = 32'd1;  // result is discarded anyway; keeps the divider defined
    qmag = ua / ub;
    rmag = ua % ub;
    quo  = (is_signed & (bus.a[31] ^ bus.b[31])) ? (32'd0 - qmag) : qmag;
    rem  = (is_signed & bus.a[31]) ? (32'd0 - rmag) : rmag;
  end

  // Next-state: start / MT writes when idle, countdown and commit when busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    pwr_d   = pwr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.mdu_op)
            OP_MULT, OP_MULTU: begin
              phi_d   = prod[63:32];
              plo_d   = prod[31:0];
              pwr_d   = 1'b1;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              phi_d   = rem;
              plo_d   = quo;
              pwr_d   = (bus.b != 32'd0);
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (pwr_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight op without touching HI/LO beyond clearing them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      pwr_q   <= pwr_d;
    end
  end

  assign bus.busy    = (state_q == S_BUSY);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = (bus.mdu_op == OP_MFHI) ? hi_q :
                       (bus.mdu_op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed architectural cases with literal expectations, then
// randomized ops compared every cycle against a transaction-level model.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mdu_if ifc();

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk_i(clk), .reset_i(rst), .bus(ifc));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: architectural HI/LO plus a result that lands after a countdown.
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_pw = 0;
  int          m_rem = 0;

  function automatic void compute(input logic [3:0] op, input logic [31:0] x, y,
                                  output logic [31:0] rh, rl, output bit ok);
    logic [63:0] p;
    int sx, sy;
    ok = 1; rh = 0; rl = 0;
    case (op)
      4'd1: begin sx = x; sy = y; p = 64'(longint'(sx) * longint'(sy)); rh = p[63:32]; rl = p[31:0]; end
      4'd2: begin p = {32'b0, x} * {32'b0, y}; rh = p[63:32]; rl = p[31:0]; end
      4'd3: begin
        if (y == 0) ok = 0;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin rl = x; rh = 0; end
        else begin sx = x; sy = y; rl = sx / sy; rh = sx % sy; end
      end
      4'd4: begin
        if (y == 0) ok = 0;
        else begin rl = x / y; rh = x % y; end
      end
      default: ok = 0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] rh, rl;
    bit ok;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_pw = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pw) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (!ifc.req) begin
      case (ifc.mdu_op)
        4'd1, 4'd2, 4'd3, 4'd4: begin
          compute(ifc.mdu_op, ifc.a, ifc.b, rh, rl, ok);
          m_phi = rh; m_plo = rl; m_pw = ok;
          m_rem = (ifc.mdu_op <= 4'd2) ? MC : DC;
        end
        4'd5: m_hi = ifc.a;
        4'd6: m_lo = ifc.a;
        default: ;
      endcase
    end
  end

  function automatic void chk(input string nm, input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endfunction

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(ifc.busy), 32'(m_rem > 0));
      chk("hi", ifc.hi, m_hi);
      chk("lo", ifc.lo, m_lo);
      chk("rd_data", ifc.rd_data,
          (ifc.mdu_op == 4'd7) ? m_hi : (ifc.mdu_op == 4'd8) ? m_lo : 32'd0);
    end
  end

  task automatic step(input logic [3:0] op, input logic [31:0] av, bv,
                      input logic rq = 1'b0, input logic rs = 1'b0);
    ifc.mdu_op = op; ifc.a = av; ifc.b = bv; ifc.req = rq; rst = rs;
    @(posedge clk); #1;
  endtask

  // Counts busy cycles after a start; bounded so a stuck busy still ends the test.
  task automatic wait_idle(output int n);
    n = 0;
    while (ifc.busy === 1'b1 && n < 50) begin n++; step(0, 0, 0); end
  endtask

  int n;
  logic [31:0] shi, slo;
  logic [31:0] pick[8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                           32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h10000};

  initial begin
    ifc.mdu_op = 0; ifc.a = 0; ifc.b = 0; ifc.req = 0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 0);
    chk("rst_busy", 32'(ifc.busy), 0);
    chk("rst_hi", ifc.hi, 0);
    chk("rst_lo", ifc.lo, 0);

    // 1: signed multiply
    step(1, 32'hFFFFFFFE, 3);
    wait_idle(n);
    chk("mult_cycles", n, MC);
    chk("mult_hi", ifc.hi, 32'hFFFFFFFF);
    chk("mult_lo", ifc.lo, 32'hFFFFFFFA);

    // 2: unsigned multiply, back-to-back start in the first idle cycle
    step(2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    chk("multu_cycles", n, MC);
    chk("multu_hi", ifc.hi, 32'hFFFFFFFE);
    chk("multu_lo", ifc.lo, 32'h00000001);

    // 3: signed divide and overflow case
    step(3, 32'hFFFFFFF9, 2);
    wait_idle(n);
    chk("div_cycles", n, DC);
    chk("div_lo", ifc.lo, 32'hFFFFFFFD);
    chk("div_hi", ifc.hi, 32'hFFFFFFFF);
    step(3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("divovf_lo", ifc.lo, 32'h80000000);
    chk("divovf_hi", ifc.hi, 32'h0);

    // 4: MTHI / MFHI, then DIVU by zero keeps HI/LO
    step(5, 32'h1234, 0);
    chk("mthi_hi", ifc.hi, 32'h1234);
    ifc.mdu_op = 7; #1;
    chk("mfhi_rd", ifc.rd_data, 32'h1234);
    step(6, 32'h5678, 0);
    shi = ifc.hi; slo = ifc.lo;
    step(4, 32'd99, 0);
    wait_idle(n);
    chk("div0_cycles", n, DC);
    chk("div0_hi", ifc.hi, 32'h1234);
    chk("div0_lo", ifc.lo, 32'h5678);

    // 5: flush drops start and MT writes
    step(1, 7, 9, 1);
    chk("req_busy", 32'(ifc.busy), 0);
    step(6, 32'hDEAD, 0, 1);
    chk("req_hi", ifc.hi, shi);
    chk("req_lo", ifc.lo, slo);

    // 6: reset in the 4th busy cycle aborts; op issued while busy is ignored
    step(3, 100, 7);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("abort_busy", 32'(ifc.busy), 0);
    chk("abort_hi", ifc.hi, 0);
    chk("abort_lo", ifc.lo, 0);
    step(3, 100, 7);
    step(1, 5, 5);
    step(5, 32'hBAD, 0, 1);
    wait_idle(n);
    chk("ign_cycles", n, DC - 2);
    chk("ign_lo", ifc.lo, 32'd14);
    chk("ign_hi", ifc.hi, 32'd2);

    // Randomized traffic; the per-cycle compare carries the checking.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] av, bv;
      av = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 7)] : $urandom;
      bv = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 15) == 0) bv = 0;
      step(4'($urandom_range(0, 10)), av, bv,
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 199) == 0));
    end
    step(0, 0, 0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
